// File: rtl/retire_trace_buffer_pkg.sv
// retire_trace_buffer_pkg: retire record layout shared with the CPU retire packer
package retire_trace_buffer_pkg;
  localparam int REC_W     = 70;
  localparam int PC_LSB    = 0;
  localparam int WDATA_LSB = 32;
  localparam int WADDR_LSB = 64;
  localparam int WEN_BIT   = 69;
  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } trace_rec_t;
  localparam int HEAD_W = $bits(trace_rec_t);
  function automatic logic writes_reg(input logic [REC_W-1:0] rec);
    return rec[WEN_BIT] && (rec[WADDR_LSB +: 5] != 5'd0);
  endfunction
endpackage

// File: rtl/retire_trace_buffer_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO that accepts a push into a full queue when a pop frees a slot the same cycle
module sync_fifo_fwft #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  // acceptance and occupancy next state
  always_comb begin
    full_o  = cnt_q == (AW+1)'(DEPTH);
    empty_o = cnt_q == '0;
    rd      = pop_i && !empty_o;
    wr      = push_i && (!full_o || rd);
    cnt_d   = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    dout_o  = mem_q[rptr_q];
  end
  // pointers and count; flush drops all queued entries
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(rd);
      cnt_q  <= cnt_d;
    end
  end
  // storage array, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: queues register-writing retirements for a trace sink, counting overflow instead of stalling
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REC_W-1:0] inst_retire,
  input  logic             clear,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_waddr,
  output logic [31:0]      trace_wdata,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);
  logic push, pop, drop, full, empty;
  trace_rec_t din, head;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, drop_cnt_q, drop_cnt_d;
  logic overflow_q;
  // qualification, drop detection and saturating counter next state
  always_comb begin
    push         = writes_reg(inst_retire);
    pop          = trace_valid && trace_ready;
    drop         = push && full && !pop;
    din          = '{waddr: inst_retire[WADDR_LSB +: 5], wdata: inst_retire[WDATA_LSB +: 32], pc: inst_retire[PC_LSB +: 32]};
    retire_cnt_d = retire_cnt_q + CNT_W'(push && !(&retire_cnt_q));
    drop_cnt_d   = drop_cnt_q + CNT_W'(drop && !(&drop_cnt_q));
  end
  sync_fifo_fwft #(.WIDTH(HEAD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .dout_o  (head)
  );
  // counters and sticky overflow; clear acts exactly like reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_q || drop;
    end
  end
  assign trace_valid = !empty;
  assign trace_pc    = head.pc;
  assign trace_waddr = head.waddr;
  assign trace_wdata = head.wdata;
  assign retire_cnt  = retire_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;
endmodule
